// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage between the PC register and IF/ID.
// Runs a req/ack transaction to instruction memory, presents the fetched
// word with its PC, and asks the controller to stall while a fetch is
// outstanding. Zero-wait (same-cycle) acknowledge sustains one fetch/cycle.
// Optional macro IF_PERF_CNT_EN builds the fetch/wait performance counters;
// without it both counter ports are tied to zero.
module if_fetch #(
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        ce,
   input  logic [5:0]  stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic        stall_req,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_wait_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic        fetch_done;

   // Only the PC-hold bit of the stall vector matters to this stage.
   logic unused_stall;
   assign unused_stall = ^stall[5:1];

   // The address always tracks the PC; the PC is held while a request waits.
   assign mem_addr = pc;

   // A completed fetch: acknowledge seen while the request is outstanding.
   assign fetch_done = (state_q == FETCH) && mem_ack && !rst;

   // Next-state and combinational outputs, so IF/ID captures on the PC edge.
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      mem_req    = 1'b0;
      stall_req  = 1'b0;
      inst_valid = 1'b0;
      inst       = NOP_INST;
      inst_pc    = '0;
      case (state_q)
         IDLE: begin
            stall_req = ce;
            if (ce) state_d = FETCH;
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               inst_valid = 1'b1;
               inst       = mem_rdata;
               inst_pc    = pc;
               inst_d     = mem_rdata;
               if (stall[0]) state_d = HOLD;
            end else begin
               stall_req = 1'b1;
            end
         end
         HOLD: begin
            inst_valid = 1'b1;
            inst       = inst_q;
            inst_pc    = pc;
            if (!stall[0]) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
      if (!ce) state_d = IDLE;
      // Reset masks the handshake outputs immediately, abandoning any request.
      if (rst) begin
         mem_req    = 1'b0;
         stall_req  = 1'b0;
         inst_valid = 1'b0;
         inst       = NOP_INST;
         inst_pc    = '0;
      end
   end

   // State register and captured-instruction register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         inst_q  <= NOP_INST;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_wait_q;

   // Free-running wrap-around counters of completed fetches and stall cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_wait_q  <= '0;
      end else begin
         if (fetch_done) perf_fetch_q <= perf_fetch_q + 32'd1;
         if (stall_req)  perf_wait_q  <= perf_wait_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_wait_cnt  = perf_wait_q;
`else
   logic unused_fetch_done;
   assign unused_fetch_done = fetch_done;
   assign perf_fetch_cnt    = '0;
   assign perf_wait_cnt     = '0;
`endif

endmodule
